// File: rtl/img_stream_out.sv
// Frame readout stage: fetches the result image word by word from shared memory
// and streams it one byte-pixel per cycle over valid/ready with sof/eol/eof markers.
module img_stream_out #(
  parameter int IMG_W     = 352,
  parameter int IMG_H     = 288,
  parameter int BASE_ADDR = 25344
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] addr,
  input  logic [31:0] dataR,
  output logic        en,
  output logic        we,
  input  logic        start,
  output logic        finish,
  output logic [7:0]  px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_sof,
  output logic        px_eol,
  output logic        px_eof
);

  localparam int          WORDS_I  = IMG_W * IMG_H / 4;
  localparam logic [15:0] WORDS    = 16'(WORDS_I);
  localparam logic [15:0] BASE     = 16'(BASE_ADDR);
  localparam int          CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int          RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [15:0]     wc, wc_cur;
  logic            rvalid;
  logic [31:0]     w0, w1, w0_n, w1_n;
  logic [1:0]      count, count_n, bi, bi_n, outstanding;
  logic [CW-1:0]   col, col_n;
  logic [RW-1:0]   row, row_n;
  logic            accept, pop, push, issue, valid_n;
  logic [7:0]      px_next;

  assign we     = 1'b0;
  assign finish = (state == DONE);

  assign accept = px_valid && px_ready;
  assign pop    = accept && (bi == 2'd3);
  assign push   = rvalid && (state == RUN);

  // Words buffered plus words requested but not yet captured; capped at two.
  assign outstanding = count + {1'b0, en} + {1'b0, rvalid};
  assign wc_cur      = (state == RUN) ? wc : 16'd0;
  assign issue       = ((state == IDLE) && start) ||
                       ((state == RUN) && (wc < WORDS) && (outstanding < 2'd2));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (accept && px_eof) state_n = DONE;
      DONE:    if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Two-word FIFO kept as head (w0) and tail (w1); the head pops once byte 3 is taken.
  always_comb begin
    w0_n    = w0;
    w1_n    = w1;
    count_n = count;
    case ({push, pop})
      2'b10: begin
        if (count == 2'd0) w0_n = dataR;
        else               w1_n = dataR;
        count_n = count + 2'd1;
      end
      2'b01: begin
        w0_n    = w1;
        count_n = count - 2'd1;
      end
      2'b11: begin
        if (count == 2'd1) begin
          w0_n = dataR;
        end else begin
          w0_n = w1;
          w1_n = dataR;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bi_n  = accept ? bi + 2'd1 : bi;
    col_n = col;
    row_n = row;
    if (accept) begin
      if (col == COL_LAST) begin
        col_n = '0;
        row_n = (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col_n = col + CW'(1);
      end
    end
    valid_n = (count_n != 2'd0) && (state_n == RUN);
    px_next = w0_n[{bi_n, 3'b000} +: 8];
  end

  // Output pixel and markers are registered from the post-update FIFO head and counters,
  // so nothing changes while a presented pixel waits for px_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      en       <= 1'b0;
      rvalid   <= 1'b0;
      wc       <= '0;
      w0       <= '0;
      w1       <= '0;
      count    <= '0;
      bi       <= '0;
      col      <= '0;
      row      <= '0;
      px_valid <= 1'b0;
      px_data  <= '0;
      px_sof   <= 1'b0;
      px_eol   <= 1'b0;
      px_eof   <= 1'b0;
    end else begin
      en     <= issue;
      rvalid <= en;
      if (issue) begin
        addr <= BASE + wc_cur;
        wc   <= wc_cur + 16'd1;
      end
      if (state == RUN) begin
        w0       <= w0_n;
        w1       <= w1_n;
        count    <= count_n;
        bi       <= bi_n;
        col      <= col_n;
        row      <= row_n;
        px_valid <= valid_n;
        if (valid_n) px_data <= px_next;
        px_sof   <= valid_n && (row_n == '0) && (col_n == '0);
        px_eol   <= valid_n && (col_n == COL_LAST);
        px_eof   <= valid_n && (row_n == ROW_LAST) && (col_n == COL_LAST);
      end else begin
        count    <= '0;
        bi       <= '0;
        col      <= '0;
        row      <= '0;
        px_valid <= 1'b0;
        px_data  <= '0;
        px_sof   <= 1'b0;
        px_eol   <= 1'b0;
        px_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_img_stream_out.sv
// Bench for img_stream_out on a reduced 32x8 frame: random image words in a memory
// model, expected pixels/markers/addresses derived from frame geometry.
module tb_img_stream_out;

  localparam int W      = 32;
  localparam int H      = 8;
  localparam int BASE   = 64;
  localparam int WORDS  = W * H / 4;
  localparam int PIX    = W * H;
  localparam int BUDGET = PIX * 4 + 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [31:0] dataR;
  logic        en, we, start, finish;
  logic [7:0]  px_data;
  logic        px_valid, px_ready, px_sof, px_eol, px_eof;

  img_stream_out #(.IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .dataR(dataR), .en(en), .we(we),
    .start(start), .finish(finish), .px_data(px_data), .px_valid(px_valid),
    .px_ready(px_ready), .px_sof(px_sof), .px_eol(px_eol), .px_eof(px_eof)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after a request; otherwise it returns noise.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (en) dataR <= (addr < 16'd256) ? mem[addr[7:0]] : 32'hDEAD_BEEF;
    else    dataR <= $urandom;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  obs_px[$];
  logic [2:0]  obs_flags[$];
  logic [15:0] obs_addr[$];
  logic [7:0]  saved_px[$];
  int first_valid, finish_at, stall_bad, max_out, we_seen, timed_out;

  function automatic logic [7:0] model_px(input int n);
    logic [31:0] w;
    w = mem[BASE + n / 4];
    return w[8 * (n % 4) +: 8];
  endfunction

  function automatic logic [2:0] model_flags(input int n);
    return {n == 0, (n % W) == W - 1, n == PIX - 1};
  endfunction

  function automatic int first_stream_mismatch();
    for (int n = 0; n < obs_px.size(); n++)
      if (n >= PIX || obs_px[n] !== model_px(n) || obs_flags[n] !== model_flags(n)) return n;
    return -1;
  endfunction

  function automatic int first_addr_mismatch();
    for (int k = 0; k < obs_addr.size(); k++)
      if (k >= WORDS || obs_addr[k] !== 16'(BASE + k)) return k;
    return -1;
  endfunction

  task automatic fill_mem(input bit pattern);
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    if (pattern)
      for (int k = 0; k < WORDS; k++)
        mem[BASE + k] = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
  endtask

  // Raises start, then per cycle: records outputs, chooses px_ready, logs accepted pixels.
  task automatic run_frame(input int mode, input bit toggle, input int stop_after);
    int cyc, acc, reqs;
    bit stalled, done;
    logic [7:0] d_prev;
    logic [2:0] f_prev;
    obs_px.delete();
    obs_flags.delete();
    obs_addr.delete();
    first_valid = -1; finish_at = -1; stall_bad = 0; max_out = 0; we_seen = 0; timed_out = 0;
    cyc = 0; acc = 0; reqs = 0; stalled = 0; done = 0; d_prev = '0; f_prev = '0;
    @(negedge clk);
    start    = 1'b1;
    px_ready = 1'b1;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (we) we_seen++;
      if (en) begin
        obs_addr.push_back(addr);
        reqs++;
      end
      if (reqs - acc / 4 > max_out) max_out = reqs - acc / 4;
      if (stalled && (!px_valid || px_data !== d_prev || {px_sof, px_eol, px_eof} !== f_prev))
        stall_bad++;
      if (px_valid && first_valid < 0) first_valid = cyc;
      if (finish) begin
        finish_at = cyc;
        done = 1;
      end else begin
        case (mode)
          0:       px_ready = 1'b1;
          1:       px_ready = (cyc % 3 == 1);
          default: px_ready = 1'($urandom_range(0, 1));
        endcase
        if (toggle) start = 1'($urandom_range(0, 1));
        if (px_valid && px_ready) begin
          obs_px.push_back(px_data);
          obs_flags.push_back({px_sof, px_eol, px_eof});
          acc++;
        end
        stalled = px_valid && !px_ready;
        d_prev  = px_data;
        f_prev  = {px_sof, px_eol, px_eof};
        if (stop_after > 0 && acc >= stop_after) done = 1;
      end
    end
    if (!done) timed_out = 1;
  endtask

  task automatic go_idle();
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; px_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (addr !== 16'd0) $display("[TB] FAIL reset_addr: got %0d expected 0", addr); else n_pass++;
    n_checks++; if (en !== 1'b0) $display("[TB] FAIL reset_en: got %b expected 0", en); else n_pass++;
    n_checks++; if (we !== 1'b0) $display("[TB] FAIL reset_we: got %b expected 0", we); else n_pass++;
    n_checks++; if (finish !== 1'b0) $display("[TB] FAIL reset_finish: got %b expected 0", finish); else n_pass++;
    n_checks++; if (px_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", px_valid); else n_pass++;
    n_checks++;
    if ({px_data, px_sof, px_eol, px_eof} !== 11'd0)
      $display("[TB] FAIL reset_data_flags: got %h expected 0", {px_data, px_sof, px_eol, px_eof});
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    int bad;
    fill_mem(1'b1);
    run_frame(0, 1'b0, 0);
    n_checks++; if (timed_out != 0) $display("[TB] FAIL full_timeout: finish not seen in %0d cycles", BUDGET); else n_pass++;
    n_checks++; if (obs_px.size() != PIX) $display("[TB] FAIL full_count: got %0d pixels expected %0d", obs_px.size(), PIX); else n_pass++;
    bad = first_stream_mismatch();
    n_checks++;
    if (bad != -1) $display("[TB] FAIL full_stream: pixel %0d got %h/%b expected %h/%b", bad,
                            obs_px[bad], obs_flags[bad], model_px(bad), model_flags(bad));
    else n_pass++;
    n_checks++; if (obs_px.size() > 0 && obs_px[PIX - 1] !== 8'((PIX - 1) % 256))
      $display("[TB] FAIL full_last_pixel: got %0d expected %0d", obs_px[PIX - 1], (PIX - 1) % 256); else n_pass++;
    n_checks++; if (obs_addr.size() != WORDS) $display("[TB] FAIL full_reads: got %0d expected %0d", obs_addr.size(), WORDS); else n_pass++;
    bad = first_addr_mismatch();
    n_checks++; if (bad != -1) $display("[TB] FAIL full_addr: read %0d got %0d expected %0d", bad, obs_addr[bad], BASE + bad); else n_pass++;
    n_checks++; if (first_valid != 3) $display("[TB] FAIL full_latency: got %0d expected 3", first_valid); else n_pass++;
    n_checks++; if (finish_at < 1 || finish_at > PIX + 4) $display("[TB] FAIL full_finish_time: got %0d expected <= %0d", finish_at, PIX + 4); else n_pass++;
    n_checks++; if (we_seen != 0) $display("[TB] FAIL full_we: got %0d cycles expected 0", we_seen); else n_pass++;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (finish !== 1'b0) $display("[TB] FAIL full_finish_drop: got %b expected 0", finish); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad;
    for (int mode = 1; mode <= 2; mode++) begin
      fill_mem(1'b0);
      run_frame(mode, 1'b0, 0);
      n_checks++; if (timed_out != 0) $display("[TB] FAIL bp_timeout: mode %0d", mode); else n_pass++;
      n_checks++; if (obs_px.size() != PIX) $display("[TB] FAIL bp_count: mode %0d got %0d expected %0d", mode, obs_px.size(), PIX); else n_pass++;
      bad = first_stream_mismatch();
      n_checks++;
      if (bad != -1) $display("[TB] FAIL bp_stream: mode %0d pixel %0d got %h/%b expected %h/%b", mode, bad,
                              obs_px[bad], obs_flags[bad], model_px(bad), model_flags(bad));
      else n_pass++;
      n_checks++; if (obs_addr.size() != WORDS) $display("[TB] FAIL bp_reads: mode %0d got %0d expected %0d", mode, obs_addr.size(), WORDS); else n_pass++;
      bad = first_addr_mismatch();
      n_checks++; if (bad != -1) $display("[TB] FAIL bp_addr: mode %0d read %0d got %0d expected %0d", mode, bad, obs_addr[bad], BASE + bad); else n_pass++;
      n_checks++; if (stall_bad != 0) $display("[TB] FAIL bp_stability: mode %0d got %0d unstable stalls expected 0", mode, stall_bad); else n_pass++;
      n_checks++; if (max_out > 2) $display("[TB] FAIL bp_outstanding: mode %0d got %0d words expected <= 2", mode, max_out); else n_pass++;
      go_idle();
    end
  endtask

  task automatic test_finish_protocol();
    int fin_low, en_hi, diff, bad;
    fill_mem(1'b0);
    run_frame(0, 1'b0, 0);
    saved_px = obs_px;
    n_checks++; if (saved_px.size() != PIX) $display("[TB] FAIL fin_first_count: got %0d expected %0d", saved_px.size(), PIX); else n_pass++;
    fin_low = 0; en_hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (!finish) fin_low++;
      if (en) en_hi++;
    end
    n_checks++; if (fin_low != 0) $display("[TB] FAIL fin_hold: finish low %0d cycles expected 0", fin_low); else n_pass++;
    n_checks++; if (en_hi != 0) $display("[TB] FAIL fin_no_read: en high %0d cycles expected 0", en_hi); else n_pass++;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (finish !== 1'b0) $display("[TB] FAIL fin_drop: got %b expected 0", finish); else n_pass++;
    @(negedge clk);
    run_frame(2, 1'b0, 0);
    n_checks++; if (obs_px.size() != PIX) $display("[TB] FAIL fin_second_count: got %0d expected %0d", obs_px.size(), PIX); else n_pass++;
    diff = 0;
    for (int n = 0; n < obs_px.size() && n < saved_px.size(); n++)
      if (obs_px[n] !== saved_px[n]) diff++;
    n_checks++; if (diff != 0) $display("[TB] FAIL fin_second_same: got %0d differing pixels expected 0", diff); else n_pass++;
    bad = first_stream_mismatch();
    n_checks++; if (bad != -1) $display("[TB] FAIL fin_second_stream: pixel %0d got %h/%b expected %h/%b", bad,
                                        obs_px[bad], obs_flags[bad], model_px(bad), model_flags(bad)); else n_pass++;
    go_idle();
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    logic [15:0] a0;
    fill_mem(1'b0);
    run_frame(2, 1'b0, 100);
    n_checks++; if (obs_px.size() != 100) $display("[TB] FAIL mid_partial: got %0d pixels expected 100", obs_px.size()); else n_pass++;
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (addr !== 16'd0) $display("[TB] FAIL mid_addr: got %0d expected 0", addr); else n_pass++;
    n_checks++; if (en !== 1'b0) $display("[TB] FAIL mid_en: got %b expected 0", en); else n_pass++;
    n_checks++; if (px_valid !== 1'b0) $display("[TB] FAIL mid_valid: got %b expected 0", px_valid); else n_pass++;
    n_checks++;
    if ({finish, px_data, px_sof, px_eol, px_eof} !== 12'd0)
      $display("[TB] FAIL mid_outputs: got %h expected 0", {finish, px_data, px_sof, px_eol, px_eof});
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    run_frame(0, 1'b0, 0);
    a0 = (obs_addr.size() > 0) ? obs_addr[0] : 16'hFFFF;
    n_checks++; if (a0 !== 16'(BASE)) $display("[TB] FAIL mid_restart_addr: got %0d expected %0d", a0, BASE); else n_pass++;
    n_checks++; if (obs_px.size() != PIX) $display("[TB] FAIL mid_restart_count: got %0d expected %0d", obs_px.size(), PIX); else n_pass++;
    bad = first_stream_mismatch();
    n_checks++; if (bad != -1) $display("[TB] FAIL mid_restart_stream: pixel %0d got %h/%b expected %h/%b", bad,
                                        obs_px[bad], obs_flags[bad], model_px(bad), model_flags(bad)); else n_pass++;
    n_checks++; if (first_valid != 3) $display("[TB] FAIL mid_restart_latency: got %0d expected 3", first_valid); else n_pass++;
    go_idle();
  endtask

  task automatic test_start_toggle();
    int bad;
    for (int mode = 0; mode <= 2; mode += 2) begin
      fill_mem(1'b0);
      run_frame(mode, 1'b1, 0);
      n_checks++; if (obs_px.size() != PIX) $display("[TB] FAIL tog_count: mode %0d got %0d expected %0d", mode, obs_px.size(), PIX); else n_pass++;
      bad = first_stream_mismatch();
      n_checks++; if (bad != -1) $display("[TB] FAIL tog_stream: mode %0d pixel %0d got %h/%b expected %h/%b", mode, bad,
                                          obs_px[bad], obs_flags[bad], model_px(bad), model_flags(bad)); else n_pass++;
      bad = first_addr_mismatch();
      n_checks++; if (bad != -1 || obs_addr.size() != WORDS)
        $display("[TB] FAIL tog_addr: mode %0d first bad %0d reads %0d expected %0d", mode, bad, obs_addr.size(), WORDS); else n_pass++;
      n_checks++; if (first_valid != 3) $display("[TB] FAIL tog_latency: mode %0d got %0d expected 3", mode, first_valid); else n_pass++;
      go_idle();
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_finish_protocol();
    test_reset_mid_frame();
    test_start_toggle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/img_stream_out.md
Name: img_stream_out

Overview:
- Downstream stage of the inversion accelerator. After that accelerator finishes, this block reads the result image from the shared word-addressed memory and streams it out one 8-bit pixel per cycle.
- The output stream uses a valid/ready handshake, for a display, UART or test-sink consumer.
- Start/finish protocol matches the other accelerators, so the top-level sequencer chains it directly.
- Read-only master on the memory bus.

Parameters:
- IMG_W, 352, pixels per row (multiple of 4)
- IMG_H, 288, rows per frame
- BASE_ADDR, 25344, word address of result-image pixel 0 (= IMG_W*IMG_H/4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addr  out  16  memory word address, registered
- dataR  in  32  memory read data, valid the cycle after en=1
- en  out  1  memory request, registered
- we  out  1  write enable, constant 0
- start  in  1  level; begin frame readout
- finish  out  1  frame fully streamed
- px_data  out  8  pixel value
- px_valid  out  1  px_data valid
- px_ready  in  1  consumer accepts pixel when px_valid&&px_ready
- px_sof  out  1  qualifies first pixel of frame
- px_eol  out  1  qualifies last pixel of each row
- px_eof  out  1  qualifies last pixel of frame

Behaviour:
- Reset (sync, active-high, one clock, single clock domain): state=IDLE; addr=0, en=0, we=0, finish=0, px_valid=0, px_data=0, all flags 0. Counters and word FIFO cleared.
- Reset mid-frame: abort at once, return to IDLE. Any read data returning on the next cycle is discarded.
- WORDS = IMG_W*IMG_H/4 = 25344. Word counter wc runs 0..WORDS-1; addr = BASE_ADDR+wc, max 50687, fits in 16 bits.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN, word counter and pixel counters cleared, FIFO empty.
- RUN, memory side:
  - Issue a read (en=1, addr=BASE_ADDR+wc, wc++) only when fifo_count + inflight < 2, where inflight = en registered last cycle.
  - Reads stop after wc reaches WORDS.
  - dataR is captured into a 2-entry word FIFO in the cycle after en=1.
- RUN, pixel side:
  - Head word serialised byte 0 ([7:0]) first, byte 3 last; byte 0 is the leftmost pixel.
  - px_valid=1 whenever a pixel is available. Earliest first px_valid is 3 cycles after start is sampled: en in cycle 1, dataR in cycle 2, px_valid in cycle 3.
  - The FIFO entry pops when byte 3 is accepted.
  - Sustained throughput is 1 pixel/cycle with px_ready held 1.
- Handshake rules:
  - px_valid, px_data and flags are registered. px_valid never depends combinationally on px_ready.
  - While px_valid && !px_ready, px_data and flags stay stable.
  - No pixel is dropped or duplicated.
- Flags, using column counter 0..IMG_W-1 and row counter 0..IMG_H-1, both advancing on accept:
  - px_sof when row=0 and col=0.
  - px_eol when col=IMG_W-1.
  - px_eof when row=IMG_H-1 and col=IMG_W-1; it coincides with px_eol.
- RUN -> DONE in the cycle after the eof pixel is accepted; px_valid=0 from then.
- DONE: finish=1 (combinational from state). start=1 stays in DONE; start=0 -> IDLE, finish drops next cycle.
- start changes during RUN are ignored.
- Frame longer than BASE_ADDR range is not possible with the default parameters; the address never wraps.

Test Plan:
- Reset: assert reset 2 cycles mid-idle -> addr=0, en=0, we=0, finish=0, px_valid=0, flags 0.
- Full frame, px_ready=1:
  - Stimulus: memory word k holds {8'(4k+3),8'(4k+2),8'(4k+1),8'(4k)} for k = BASE_ADDR.., start=1.
  - Required: 101376 pixels, pixel n = n mod 256; px_sof only on pixel 0; px_eol on pixels 351, 703, …, 101375; px_eof only on pixel 101375; first px_valid 3 cycles after start; finish ≤101380 cycles after start; we never 1.
- Backpressure: px_ready pattern 1,0,0 repeating, plus random -> identical pixel sequence; data stable across every stall; addresses strictly incrementing 25344..50687; never more than 2 words buffered or in flight.
- Finish protocol: hold start=1 after DONE -> finish stays 1, no new en; drop start -> IDLE, finish 0 next cycle; second start pulse -> second identical frame.
- Reset mid-frame after pixel 1000 -> outputs cleared next cycle; restart streams from pixel 0 with px_sof=1 and addr=25344.
- Toggle start during RUN -> no effect on the pixel stream or address sequence.
